// File: rtl/sprite_rom_arbiter_if.sv
// Requester-side bus of the sprite ROM arbiter: level requests, flattened
// addresses, burst-lock hints, one-hot grant and one-hot return strobe.
interface sprite_rom_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 4
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ-1:0]        gnt;
  logic [DATA_W-1:0]       rdata;
  logic [N_REQ-1:0]        rvalid;

  modport slave  (input  req, addr, lock, output gnt, rdata, rvalid);
  modport master (output req, addr, lock, input  gnt, rdata, rvalid);
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin share of one sprite palette-index ROM among N_REQ renderers.
// Optional burst lock (priority stays on a locking winner): SPRITE_ROM_ARB_LOCK_EN.
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                vga_clk,
  input  logic                reset_n,
  sprite_rom_arbiter_if.slave rd,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_q
);
  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(N_REQ - 1);

  logic [PTR_W-1:0]              ptr, ptr_nxt, win;
  logic                          found, xfer;
  logic [N_REQ-1:0]              gnt_c;
  logic [N_REQ-1:0][ADDR_W-1:0]  addr_a;
  logic [ROM_LAT-1:0]            vld_pipe;
  logic [ROM_LAT-1:0][PTR_W-1:0] idx_pipe;
  logic [DATA_W-1:0]             rdata_q;
  logic [N_REQ-1:0]              rvalid_q;

  for (genvar g = 0; g < N_REQ; g++) begin : g_addr
    assign addr_a[g] = rd.addr[g*ADDR_W +: ADDR_W];
  end

  // Scan upward from ptr with wrap; first requesting index wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rd.req[(int'(ptr) + k) % N_REQ]) begin
        found = 1'b1;
        win   = PTR_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  assign xfer = found & reset_n;

  always_comb begin
    gnt_c = '0;
    if (xfer) gnt_c[win] = 1'b1;
  end

  assign rd.gnt    = gnt_c;
  assign rd.rdata  = rdata_q;
  assign rd.rvalid = rvalid_q;

  always_comb begin
    ptr_nxt = (win == LAST) ? '0 : win + 1'b1;
`ifdef SPRITE_ROM_ARB_LOCK_EN
    if (rd.lock[win]) ptr_nxt = win;
`endif
  end

`ifndef SPRITE_ROM_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^rd.lock;
`endif

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr      <= '0;
      rom_addr <= '0;
    end else if (xfer) begin
      ptr      <= ptr_nxt;
      rom_addr <= addr_a[win];
    end
  end

  // Tag pipeline tracks which requester owns the read currently in the ROM.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      vld_pipe[0] <= xfer;
      idx_pipe[0] <= win;
      for (int s = 1; s < ROM_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        idx_pipe[s] <= idx_pipe[s-1];
      end
      rvalid_q <= '0;
      if (vld_pipe[ROM_LAT-1]) begin
        rdata_q  <= rom_q;
        rvalid_q <= N_REQ'(1) << idx_pipe[ROM_LAT-1];
      end
    end
  end
endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one single-port sprite ROM (palette-index ROM clocked on the inverted pixel clock) among `N_REQ` sprite/tile renderers in the VGA pixel pipeline. Requesters present ROM addresses with a valid/ready handshake. A round-robin arbiter issues one ROM read per clock. Each returned palette index goes back to the requester that issued the read, with a one-hot valid. The block sits between the per-object draw logic and the shared ROM/palette pair.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `ADDR_W`, 7: ROM address width.
- `DATA_W`, 4: ROM data (palette index) width.
- `ROM_LAT`, 1: number of rising edges from `rom_addr` update to `rom_q` being valid for capture (1..4).

Ports:
- `vga_clk`  in  1  pixel clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester read request (level).
- `addr`  in  N_REQ*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- `lock`  in  N_REQ  burst-lock hint; used only when the lock feature is compiled in.
- `gnt`  out  N_REQ  combinational one-hot grant.
- `rom_addr`  out  ADDR_W  registered address to the shared ROM.
- `rom_q`  in  DATA_W  ROM read data.
- `rdata`  out  DATA_W  registered return data.
- `rvalid`  out  N_REQ  registered one-hot return strobe.

## Operation
- Transfer: on the rising edge where `req[i] & gnt[i]`. The requester holds `req[i]` and its `addr` slice stable until that edge.
- Grant: combinational, one-hot or zero.
  - `gnt` is all-zero when `req == 0` or while `reset_n` is low.
  - The winner is the first set `req` bit, scanning upward from `ptr` and wrapping `N_REQ-1` → 0.
- Pointer `ptr` (clog2(N_REQ) bits):
  - Resets to 0.
  - After a transfer to requester i: `ptr <= (i+1) mod N_REQ`.
  - Unchanged in cycles with no transfer.
- On a transfer edge: `rom_addr <= addr[i]`. Otherwise `rom_addr` holds.
- Tag pipeline: `ROM_LAT` stages of {valid, index}.
  - Stage 0 loads {1, i} on a transfer and {0, x} otherwise.
  - Stages shift every edge.
- Output stage: when the last tag stage is valid for index k, then on the next edge `rdata <= rom_q` and `rvalid <= onehot(k)`.
  - Otherwise `rvalid <= 0` and `rdata` holds.
- Throughput: one read per clock sustained, with no bubbles between back-to-back grants to different or the same requesters.
- Simultaneous events: a new transfer and a return in the same edge are independent; both proceed.
- Reset (any time, including mid-flight):
  - `rom_addr=0`, `rdata=0`, `rvalid=0`, `ptr=0`, all tag stages invalid, lock state cleared.
  - In-flight reads are dropped and never return.

## Timing
- Transfer edge E0 updates `rom_addr`.
- `rom_q` is sampled at edge E0+ROM_LAT.
- `rvalid`/`rdata` are visible in the cycle after E0+ROM_LAT: ROM_LAT+1 edges transfer-to-valid, i.e. 2 for the default.
- `rvalid` is high for exactly one cycle per transfer, and returns arrive in transfer order.
- `gnt` has no registered delay; a requester sees grant in the same cycle it asserts `req`.
- Worst-case wait for a continuously requesting master without lock: N_REQ-1 cycles.

## Configuration
- Macro: `SPRITE_ROM_ARB_LOCK_EN`.
- Defined:
  - A transfer to requester i with `lock[i]=1` leaves `ptr = i`, so i keeps top priority next cycle.
  - Priority rotates normally on the first transfer to i with `lock[i]=0`.
  - Priority also rotates if i deasserts `req` while still owning priority.
  - Worst-case wait becomes unbounded while a lock is held.
- Undefined: the `lock` port exists but is ignored, and arbitration is pure round-robin.

## Test plan
- Single requester: `req=4'b0010`, `addr[1]=7'h2A` held 1 cycle → `gnt=4'b0010` that cycle, `rom_addr=7'h2A` next, `rvalid=4'b0010` with `rdata=rom[0x2A]` exactly 2 edges after transfer.
- All four request continuously from reset for 8 cycles → grant order 0,1,2,3,0,1,2,3; `rvalid` follows the same order delayed 2 cycles, one per cycle, no gaps.
- Requesters 0 and 2 continuously, 1 and 3 idle → alternating grants 0,2,0,2; pointer skips idle indices.
- `ROM_LAT=2` build, back-to-back transfers to 3 then 1 → `rvalid` 4'b1000 then 4'b0010 at 3 and 4 edges after the first transfer, with matching data.
- Assert `reset_n` low one cycle after two transfers → `rvalid`, `rdata`, `rom_addr` go 0 immediately, no late `rvalid` after release, and the first post-reset grant goes to requester 0 when all request.
- With `SPRITE_ROM_ARB_LOCK_EN`, all requesting, `lock[1]=1` for 3 transfers then 0 → grants 0,1,1,1,1,2,3 (the fourth grant to 1 occurs with lock low and releases priority).
